// File: rtl/req_fifo_arbiter_pkg.sv
// Shared types and defaults for the CPU request FIFO arbiter and its
// reusable round-robin selector.
package req_fifo_arbiter_pkg;

  localparam int CPU_DATA_WIDTH    = 16;
  localparam int REQ_ARB_NUM_REQ   = 4;
  localparam int REQ_ARB_MAX_WORDS = 8;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Index width for a requester vector; a single requester still gets one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_fifo_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first valid requester
// strictly after last_grant, wrapping around, so last_grant itself is checked last.
module rr_pick
  import req_fifo_arbiter_pkg::*;
#(
  parameter int N  = REQ_ARB_NUM_REQ,
  parameter int GW = grant_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          found
);

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (valid[idx]) begin
        grant = GW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_fifo_arbiter.sv
// Round-robin arbiter sharing the CPU request FIFO write port; a grant is
// locked for a whole burst and bursts longer than MAX_WORDS are cut and flagged.
module req_fifo_arbiter
  import req_fifo_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = REQ_ARB_NUM_REQ,
  parameter  int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter  int MAX_WORDS  = REQ_ARB_MAX_WORDS,
  localparam int GW         = grant_width(NUM_REQ),
  localparam int CW         = $clog2(MAX_WORDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         req_fifo_data_in,
  output logic                          req_fifo_enq,
  input  logic                          req_fifo_wrfull,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            overrun_err,
  input  logic                          err_clr
);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [CW-1:0]      word_cnt;
  logic [GW-1:0]      pick_grant;
  logic               pick_found;
  logic               accept;
  logic               cap_hit;
  logic [NUM_REQ-1:0] err_next;

  rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
    .valid      (req_valid),
    .last_grant (grant_id),
    .grant      (pick_grant),
    .found      (pick_found)
  );

  // Outputs are gated by rst so the FIFO sees nothing while reset is held,
  // even before the asynchronous state clear has propagated.
  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    cap_hit          = 1'b0;
    req_ready        = '0;
    req_fifo_enq     = 1'b0;
    req_fifo_data_in = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) state_next = ARB_BURST;
      end
      ARB_BURST: begin
        if (!rst) begin
          req_ready[grant_id] = !req_fifo_wrfull;
          accept              = req_valid[grant_id] && !req_fifo_wrfull;
        end
        cap_hit      = accept && !req_last[grant_id] && (word_cnt == CW'(MAX_WORDS - 1));
        req_fifo_enq = accept;
        if (accept) begin
          req_fifo_data_in = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
          if (req_last[grant_id] || cap_hit) state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // A new overrun on the same edge as err_clr must survive the clear.
  always_comb begin
    err_next = err_clr ? '0 : overrun_err;
    if (cap_hit) err_next[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant_id    <= GW'(NUM_REQ - 1);
      word_cnt    <= '0;
      overrun_err <= '0;
    end else begin
      state       <= state_next;
      overrun_err <= err_next;
      if (state == ARB_IDLE && pick_found) begin
        grant_id <= pick_grant;
        word_cnt <= '0;
      end else if (accept) begin
        word_cnt <= word_cnt + CW'(1);
      end
    end
  end

  assign busy = (state == ARB_BURST);

endmodule

// File: tb/tb_req_fifo_arbiter.sv
// Self-checking bench for req_fifo_arbiter: a scoreboard queue of expected FIFO
// writes plus a table of burst vectors and hand-written multi-cycle sequences.
module tb_req_fifo_arbiter;
  import req_fifo_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, overrun_err;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   req_fifo_data_in;
  logic            req_fifo_enq, req_fifo_wrfull, busy, err_clr;
  logic [1:0]      grant_id;

  logic          drv_valid [N];
  logic          drv_last  [N];
  logic [DW-1:0] drv_data  [N];

  typedef struct {
    logic [DW-1:0] data;
    int            src;
  } exp_t;

  typedef struct {
    int         id;
    int         len;
    bit         last;
    bit         clr;
    logic [3:0] exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   errors = 0;
  int   checks = 0;
  int   enq_count = 0;
  int   cycle = 0;
  int   last_enq_cycle = 0;
  int   last_src = -1;
  bit   check_bubble = 1'b0;

  req_fifo_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .req_fifo_data_in (req_fifo_data_in),
    .req_fifo_enq     (req_fifo_enq),
    .req_fifo_wrfull  (req_fifo_wrfull),
    .grant_id         (grant_id),
    .busy             (busy),
    .overrun_err      (overrun_err),
    .err_clr          (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = drv_valid[i];
      req_last[i]            = drv_last[i];
      req_data[i*DW +: DW]   = drv_data[i];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int s);
    exp_t t;
    t.data = d;
    t.src  = s;
    sb.push_back(t);
  endtask

  // Monitor: every FIFO write is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_fifo_enq === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_enq: got data %h from %0d expected no write", req_fifo_data_in, grant_id);
        end else begin
          e = sb.pop_front();
          check_output("fifo_data", 32'(req_fifo_data_in), 32'(e.data));
          check_output("fifo_src", 32'(grant_id), 32'(e.src));
        end
        if (check_bubble && last_src >= 0 && last_src != int'(grant_id))
          check_output("bubble_gap", 32'(cycle - last_enq_cycle), 32'd2);
        last_enq_cycle = cycle;
        last_src       = int'(grant_id);
        enq_count++;
      end else begin
        check_output("data_zero_no_enq", 32'(req_fifo_data_in), 32'd0);
      end
    end
  end

  // Drives one requester word by word, holding each word until accepted;
  // an optional gap drops valid mid-burst and checks the grant is held.
  task automatic apply_stimulus(input int id, input int n, input bit with_last,
                                input logic [DW-1:0] base, input int step,
                                input int gap_at, input int gap_len);
    int i;
    int guard;
    bit acc;
    i     = 0;
    guard = 0;
    while (i < n && guard < 200) begin
      if (i == gap_at && gap_len > 0) begin
        drv_valid[id] = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          check_output("gap_enq", 32'(req_fifo_enq), 32'd0);
          check_output("gap_grant", 32'(grant_id), 32'(id));
          check_output("gap_other_ready", 32'(req_ready & ~(N'(1) << id)), 32'd0);
          @(posedge clk); #1;
        end
        gap_len = 0;
      end
      drv_valid[id] = 1'b1;
      drv_last[id]  = with_last && (i == n - 1);
      drv_data[id]  = base + DW'(i * step);
      @(negedge clk);
      acc = req_ready[id];
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    drv_valid[id] = 1'b0;
    drv_last[id]  = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL driver_timeout: requester %0d got %0d words accepted expected %0d", id, i, n);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic two_singles(input int id);
    apply_stimulus(id, 1, 1'b1, 16'h1000 + DW'(id), 1, -1, 0);
    apply_stimulus(id, 1, 1'b1, 16'h1000 + DW'(id), 1, -1, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{id: 0, len: 1, last: 1'b1, clr: 1'b0, exp_err: 4'b0000};
    vecs[1] = '{id: 1, len: 8, last: 1'b1, clr: 1'b0, exp_err: 4'b0000};
    vecs[2] = '{id: 1, len: 8, last: 1'b0, clr: 1'b0, exp_err: 4'b0010};
    vecs[3] = '{id: 2, len: 8, last: 1'b0, clr: 1'b1, exp_err: 4'b0100};
    vecs[4] = '{id: 3, len: 3, last: 1'b1, clr: 1'b1, exp_err: 4'b0000};

    rst = 1'b1;
    req_fifo_wrfull = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
      drv_data[i]  = '0;
    end
    drv_valid[0] = 1'b1;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_enq", 32'(req_fifo_enq), 32'd0);
    check_output("rst_ready", 32'(req_ready), 32'd0);
    check_output("rst_grant", 32'(grant_id), 32'd3);
    check_output("rst_overrun", 32'(overrun_err), 32'd0);
    drv_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Three-word burst from requester 0 with first-write latency of one cycle.
    push_exp(16'hAAAA, 0);
    push_exp(16'hBBBB, 0);
    push_exp(16'hCCCC, 0);
    fork
      apply_stimulus(0, 3, 1'b1, 16'hAAAA, 16'h1111, -1, 0);
      begin
        @(negedge clk);
        check_output("lat_first_cycle_enq", 32'(req_fifo_enq), 32'd0);
        repeat (3) begin
          @(negedge clk);
          check_output("lat_burst_enq", 32'(req_fifo_enq), 32'd1);
        end
        @(negedge clk);
        check_output("lat_after_enq", 32'(req_fifo_enq), 32'd0);
        check_output("lat_after_busy", 32'(busy), 32'd0);
      end
    join
    check_output("t1_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Table of bursts: length boundaries, overrun flags and clear-vs-set.
    pulse_reset();
    for (int v = 0; v < 5; v++) begin
      for (int w = 0; w < vecs[v].len; w++)
        push_exp(16'h5000 + DW'(v * 16 + w), vecs[v].id);
      err_clr = vecs[v].clr;
      apply_stimulus(vecs[v].id, vecs[v].len, vecs[v].last, 16'h5000 + DW'(v * 16), 1, -1, 0);
      err_clr = 1'b0;
      check_output("vec_overrun", 32'(overrun_err), 32'(vecs[v].exp_err));
      check_output("vec_busy", 32'(busy), 32'd0);
      check_output("vec_grant", 32'(grant_id), 32'(vecs[v].id));
      check_output("vec_drain", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
    end

    // All requesters sending single-word bursts rotate with one bubble each.
    pulse_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_exp(16'h1000 + DW'(i), i);
    last_src = -1;
    check_bubble = 1'b1;
    fork
      two_singles(0);
      two_singles(1);
      two_singles(2);
      two_singles(3);
    join
    check_bubble = 1'b0;
    check_output("rr_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // FIFO full for two cycles after the second word of a four-word burst.
    for (int w = 0; w < 4; w++) push_exp(16'h4000 + DW'(w), 1);
    fork
      apply_stimulus(1, 4, 1'b1, 16'h4000, 1, -1, 0);
      begin : wrfull_blk
        int start;
        int g;
        start = enq_count;
        g = 0;
        while (enq_count < start + 2 && g < 50) begin
          @(negedge clk); #1;
          g++;
        end
        if (g >= 50) check_output("wrfull_wait_timeout", 32'(enq_count - start), 32'd2);
        @(posedge clk); #1;
        req_fifo_wrfull = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check_output("wrfull_enq", 32'(req_fifo_enq), 32'd0);
          check_output("wrfull_ready", 32'(req_ready), 32'd0);
          check_output("wrfull_busy", 32'(busy), 32'd1);
          @(posedge clk); #1;
        end
        req_fifo_wrfull = 1'b0;
      end
    join
    check_output("wrfull_drain", 32'(sb.size()), 32'd0);
    check_output("wrfull_idle", 32'(busy), 32'd0);

    // Ten unterminated words from requester 2 with requester 1 waiting.
    pulse_reset();
    for (int w = 0; w < 8; w++) push_exp(16'h2000 + DW'(w), 2);
    push_exp(16'h1111, 1);
    push_exp(16'h2008, 2);
    push_exp(16'h2009, 2);
    fork
      apply_stimulus(2, 10, 1'b0, 16'h2000, 1, -1, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        apply_stimulus(1, 1, 1'b1, 16'h1111, 1, -1, 0);
      end
    join
    check_output("ovr_drain", 32'(sb.size()), 32'd0);
    check_output("ovr_flag", 32'(overrun_err), 32'b0100);
    check_output("ovr_still_busy", 32'(busy), 32'd1);
    check_output("ovr_grant", 32'(grant_id), 32'd2);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_output("ovr_cleared", 32'(overrun_err), 32'd0);

    // Reset in the middle of a requester 3 burst, requester 0 pending.
    pulse_reset();
    drv_valid[3] = 1'b1;
    drv_data[3]  = 16'h3000;
    drv_last[3]  = 1'b0;
    push_exp(16'h3000, 3);
    push_exp(16'h3000, 3);
    @(posedge clk); #1;
    drv_valid[0] = 1'b1;
    drv_data[0]  = 16'h0A0A;
    drv_last[0]  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("midrst_enq", 32'(req_fifo_enq), 32'd0);
    check_output("midrst_ready", 32'(req_ready), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_data", 32'(req_fifo_data_in), 32'd0);
    check_output("midrst_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(16'h0A0A, 0);
    push_exp(16'h3333, 3);
    fork
      apply_stimulus(0, 1, 1'b1, 16'h0A0A, 1, -1, 0);
      apply_stimulus(3, 1, 1'b1, 16'h3333, 1, -1, 0);
    join
    check_output("postrst_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Requester 0 pauses mid-burst while requester 1 waits.
    for (int w = 0; w < 4; w++) push_exp(16'h6000 + DW'(w), 0);
    push_exp(16'h6100, 1);
    fork
      apply_stimulus(0, 4, 1'b1, 16'h6000, 1, 2, 3);
      begin
        repeat (2) @(posedge clk);
        #1;
        apply_stimulus(1, 1, 1'b1, 16'h6100, 1, -1, 0);
      end
    join
    check_output("gap_drain", 32'(sb.size()), 32'd0);
    check_output("gap_idle", 32'(busy), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_fifo_arbiter.md
Name: req_fifo_arbiter

Overview:
Round-robin arbiter that shares the single write port of the CPU request FIFO (fifo_ack, consumed by cpu_rmc via req_fifo_deq/req_fifo_rdempty) between NUM_REQ requesters. Each requester sends multi-word requests (bursts) closed by a last flag. The arbiter locks the grant for a whole burst so words from different requesters never interleave in the FIFO. It caps every burst at MAX_WORDS and flags overruns.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_WIDTH, CPU_DATA_WIDTH (16), request word width
MAX_WORDS, 8, maximum words per burst (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester word valid
req_last  in  NUM_REQ  per-requester last word of burst, qualified by req_valid
req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  word accepted when req_valid[i] && req_ready[i]
req_fifo_data_in  out  DATA_WIDTH  to FIFO data_in
req_fifo_enq  out  1  to FIFO enq
req_fifo_wrfull  in  1  from FIFO wrfull
grant_id  out  max(1,$clog2(NUM_REQ))  current/last granted requester
busy  out  1  high while in BURST
overrun_err  out  NUM_REQ  sticky per-requester overrun flag
err_clr  in  1  synchronous clear of overrun_err

Behaviour:
- Reset (async, rst=1): state=IDLE; grant_id=NUM_REQ-1 (requester 0 wins first); word_cnt=0; overrun_err=0; busy=0. req_ready, req_fifo_enq and req_fifo_data_in are forced to 0 while rst=1.
- States: IDLE, BURST.
- IDLE: req_ready=0, enq=0. If any req_valid is set, pick the first valid requester searching from grant_id+1 upward, wrapping modulo NUM_REQ. Register it into grant_id, set word_cnt=0 and go to BURST. With no valid requests, stay in IDLE.
- BURST, g=grant_id:
  - req_ready[g]=!req_fifo_wrfull; all other ready bits 0.
  - req_fifo_enq = req_valid[g] && !req_fifo_wrfull.
  - req_fifo_data_in = word g of req_data. This is a combinational pass-through and must be 0 when enq=0.
  - On each accepted word, word_cnt increments.
  - Accepted word with req_last[g]=1: go to IDLE.
  - Accepted word with word_cnt==MAX_WORDS-1 and req_last[g]=0: forced release. Set overrun_err[g] and go to IDLE. Further words from g are arbitrated as a new burst.
- Latency: request valid in IDLE at cycle N means grant at edge N+1 and the first enq in cycle N+1, unless wrfull. Burst words then flow one per cycle. There is exactly one idle bubble cycle between bursts.
- req_valid[g] low mid-burst: grant is held with no timeout; enq=0; other requesters stall.
- req_fifo_wrfull high: no enq, no ready, word_cnt and state hold. No word is lost or duplicated.
- err_clr clears all overrun_err bits. When clear and set occur in the same cycle, set wins for that bit.
- Reset mid-burst: returns to IDLE immediately. Words already written stay in the FIFO; the FIFO's reset is separate.
- NUM_REQ=1: grant_id is 1 bit wide and always 0.
- word_cnt width: $clog2(MAX_WORDS+1).

Decomposition:
- cpuPkg gains:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t
  - REQ_ARB_NUM_REQ and REQ_ARB_MAX_WORDS defaults
  - reuse of CPU_DATA_WIDTH
- One sub-module, rr_pick: combinational round-robin selector. Inputs: valid vector and last grant. Outputs: next grant index and found flag. Reusable by other arbiters.

Test Plan:
- Req0 sends AAAA,BBBB,CCCC (last on CCCC), others idle -> grant_id=0, enq high for 3 consecutive cycles from the cycle after valid, FIFO output AAAA,BBBB,CCCC, busy falls afterward, CPU dequeues all 3.
- All 4 requesters continuously send single-word bursts (data 16'h1000+i) -> FIFO order 1000,1001,1002,1003,1000; one bubble between each.
- Req1 sends a 4-word burst; wrfull forced high for 2 cycles after word 2 -> enq/ready low for those cycles, FIFO receives exactly 4 words in order, word_cnt frozen.
- Req2 sends 10 words with no last, req1 pending -> 8 words from req2, overrun_err=4'b0100, next grant=1, then req2 remaining 2 words; err_clr pulse -> overrun_err=0.
- Req3 mid-burst, req0 pending, rst pulsed -> enq/ready/busy=0 asynchronously; after release req0 is granted first.
- Req0 drops req_valid for 3 cycles mid-burst while req1 valid -> grant stays 0, req_ready[1]=0, burst resumes with no interleaving.
